if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Fetch-side pipeline stage directly downstream of the program counter.
- Computes PC+4 and the next-PC select that feeds the PC input (with its write enable).
- Registers the fetched instruction and PC into the IF/ID boundary, with stall (hold), flush (bubble) and valid tracking.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- PC_W, 16, width of program counter and all address paths
- INSTR_W, 32, instruction word width
- NOP_INSTR, 32'h0000_0000, instruction value injected on flush/reset
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- pc_i  input  PC_W  current PC from the program counter
- instr_i  input  INSTR_W  combinational instruction-memory read data at pc_i
- pc_src_i  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 reserved (treated as seq)
- branch_target_i  input  PC_W  branch target from ID/EX
- jump_target_i  input  PC_W  jump target from ID
- IF_ID_write  input  1  1 = load IF/ID register, 0 = hold (stall from hazard unit)
- flush_i  input  1  discard the instruction being fetched; load bubble
- pc_next_o  output  PC_W  combinational next PC to the program counter input
- pc_write_o  output  1  write enable to the program counter
- pc_o  output  PC_W  registered IF/ID PC
- pc_plus4_o  output  PC_W  registered IF/ID PC+4
- instr_o  output  INSTR_W  registered IF/ID instruction
- valid_o  output  1  IF/ID register holds a real instruction
- stall_cnt_o  output  CNT_W  saturating count of stalled cycles
- flush_cnt_o  output  CNT_W  saturating count of flush cycles

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: pc_o = 0, pc_plus4_o = 0, instr_o = NOP_INSTR, valid_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
- Reset has priority over every other input, including mid-stall and mid-flush.
- Combinational next-PC path:
  - pc_plus4 = pc_i + 4, modulo 2^PC_W. 16'hFFFC + 4 wraps to 16'h0000.
  - pc_next_o = branch_target_i when pc_src_i = 01, jump_target_i when pc_src_i = 10, else pc_plus4.
  - pc_write_o = IF_ID_write | flush_i. A taken redirect is never lost to a stall.
  - pc_write_o is forced to 0 while rst_i = 1.
- IF/ID register update, priority rst_i > flush_i > IF_ID_write:
  - flush_i = 1: instr_o <= NOP_INSTR, valid_o <= 0, pc_o <= pc_i, pc_plus4_o <= pc_plus4. Flush overrides a simultaneous stall.
  - flush_i = 0 and IF_ID_write = 1: instr_o <= instr_i, pc_o <= pc_i, pc_plus4_o <= pc_plus4, valid_o <= 1.
  - flush_i = 0 and IF_ID_write = 0: all IF/ID outputs hold their values.
- Latency: instruction at pc_i in cycle N appears on instr_o in cycle N+1 when loaded.
- Counters:
  - stall_cnt_o increments each cycle with IF_ID_write = 0 and flush_i = 0.
  - flush_cnt_o increments each cycle with flush_i = 1.
  - Both saturate at all-ones and never wrap.
- Pipeline state machine, held in valid_o: EMPTY (valid 0) / FULL (valid 1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on flush.
  - Stall keeps the current state.
  - The first load after reset leaves EMPTY.
- pc_src_i = 11 behaves exactly as 00.
- No X propagation: all registers are reset.

Decomposition:
- Shared package cpu_pkg:
  - PC_W, INSTR_W, NOP_INSTR constants
  - pc_src encoding localparams: PC_SRC_SEQ, PC_SRC_BR, PC_SRC_JMP
- One natural sub-module, sat_counter (CNT_W, increment enable, sync reset), instantiated twice.
- The next-PC mux stays inline.

Test Plan:
- Reset then run: rst_i = 1 for 2 cycles, then pc_i = 0x0000, instr_i = 0x2001_0005, IF_ID_write = 1 -> cycle after release: instr_o = 0x2001_0005, pc_o = 0, pc_plus4_o = 4, valid_o = 1; pc_next_o = 4 and pc_write_o = 1 throughout.
- Stall hold: loaded with pc_i = 0x0010 / instr 0x8C22_0000, then IF_ID_write = 0 for 3 cycles while instr_i changes to 0xDEAD_BEEF -> instr_o stays 0x8C22_0000, pc_write_o = 0, stall_cnt_o = 3.
- Branch flush during stall: IF_ID_write = 0, flush_i = 1, pc_src_i = 01, branch_target_i = 0x0040 -> pc_next_o = 0x0040, pc_write_o = 1; next cycle instr_o = NOP_INSTR, valid_o = 0, flush_cnt_o = 1, stall_cnt_o unchanged.
- Jump and wrap: pc_src_i = 10, jump_target_i = 0x1234 -> pc_next_o = 0x1234. pc_src_i = 00 with pc_i = 0xFFFC -> pc_next_o = 0x0000. pc_src_i = 11 with pc_i = 0x0008 -> 0x000C.
- Reset mid-operation: valid_o = 1, stall_cnt_o = 5, flush_i = 1 and rst_i = 1 in the same cycle -> next cycle all outputs equal their reset values and pc_write_o = 0 during reset.
- Counter saturation: CNT_W = 4, hold IF_ID_write = 0 for 20 cycles -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path constants and encodings
//
// Purpose: widths, the bubble instruction, next-PC select encodings and the
// IF/ID occupancy state type shared by the fetch stage files.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Next-PC select; 2'b11 is reserved and decodes as sequential.
  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  // IF/ID occupancy, mirrored directly on valid_o.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch-side signal bundle for the IF/ID stage
//
// Purpose: groups every non-clock/reset signal of if_id_stage.
// Ports (signals):
//   pc_i, instr_i, pc_src_i, branch_target_i, jump_target_i,
//   IF_ID_write, flush_i                  : driven by fetch/hazard logic
//   pc_next_o, pc_write_o                 : to the program counter
//   pc_o, pc_plus4_o, instr_o, valid_o    : IF/ID register contents
//   stall_cnt_o, flush_cnt_o              : debug event counters
// Modports: master drives the inputs, slave is the stage itself.
interface if_id_stage_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int CNT_W   = 16
);

  logic [PC_W-1:0]    pc_i;
  logic [INSTR_W-1:0] instr_i;
  logic [1:0]         pc_src_i;
  logic [PC_W-1:0]    branch_target_i;
  logic [PC_W-1:0]    jump_target_i;
  logic               IF_ID_write;
  logic               flush_i;

  logic [PC_W-1:0]    pc_next_o;
  logic               pc_write_o;
  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    pc_plus4_o;
  logic [INSTR_W-1:0] instr_o;
  logic               valid_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  modport master (
    output pc_i, instr_i, pc_src_i, branch_target_i, jump_target_i,
           IF_ID_write, flush_i,
    input  pc_next_o, pc_write_o, pc_o, pc_plus4_o, instr_o, valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pc_i, instr_i, pc_src_i, branch_target_i, jump_target_i,
           IF_ID_write, flush_i,
    output pc_next_o, pc_write_o, pc_o, pc_plus4_o, instr_o, valid_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous reset
//
// Purpose: counts enabled cycles and sticks at all-ones.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (clears to zero)
//   inc_i  count this cycle
//   cnt_o  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch next-PC select and IF/ID pipeline register
//
// Purpose: computes PC+4 and the next PC (with its write enable), registers
// the fetched instruction/PC into IF/ID with stall, flush and valid tracking,
// and keeps saturating stall/flush event counters.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  synchronous active-high reset, highest priority
//   bus    if_id_stage_if.slave carrying the fetch inputs, next-PC outputs,
//          IF/ID register outputs and the debug counters
module if_id_stage #(
  parameter int                 PC_W      = cpu_pkg::PC_W,
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int                 CNT_W     = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  if_id_stage_if.slave bus
);

  import cpu_pkg::*;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_next;
  logic            load_ev;
  logic            stall_ev;

  pipe_state_e state_q;
  pipe_state_e state_d;

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_plus4_q;
  logic [INSTR_W-1:0] instr_q;

  // Wraps naturally modulo 2^PC_W.
  assign pc_plus4 = bus.pc_i + PC_W'(4);

  always_comb begin
    pc_next = pc_plus4;
    case (bus.pc_src_i)
      PC_SRC_BR:  pc_next = bus.branch_target_i;
      PC_SRC_JMP: pc_next = bus.jump_target_i;
      default:    pc_next = pc_plus4;
    endcase
  end

  assign bus.pc_next_o = pc_next;

  // A flush advances the PC even during a hazard stall so the redirect
  // target is not dropped.
  assign bus.pc_write_o = ~rst_i & (bus.IF_ID_write | bus.flush_i);

  assign load_ev  = ~bus.flush_i & bus.IF_ID_write;
  assign stall_ev = ~bus.flush_i & ~bus.IF_ID_write;

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = ST_EMPTY;
    end else if (load_ev) begin
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // The bubble still records the PC it replaced, so debug sees where the
  // discarded fetch was.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else if (bus.flush_i) begin
      pc_q       <= bus.pc_i;
      pc_plus4_q <= pc_plus4;
      instr_q    <= NOP_INSTR;
    end else if (bus.IF_ID_write) begin
      pc_q       <= bus.pc_i;
      pc_plus4_q <= pc_plus4;
      instr_q    <= bus.instr_i;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_plus4_q;
  assign bus.instr_o    = instr_q;
  assign bus.valid_o    = (state_q == ST_FULL);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_ev),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.flush_i),
    .cnt_o (bus.flush_cnt_o)
  );

endmodule
